// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  localparam int unsigned ARB_NUM_PORTS = 2;
  localparam int unsigned ARB_ADDR_W    = 32;
  localparam int unsigned ARB_DATA_W    = 32;
  localparam int unsigned PORT_IDX_W    = $clog2(ARB_NUM_PORTS);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  // Latched winning command, held for the single ACCESS cycle.
  typedef struct packed {
    logic [PORT_IDX_W-1:0] idx;
    logic                  we;
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_DATA_W-1:0] wdata;
  } cmd_t;

  // Round-robin successor: the port after the winner, wrapping at n.
  function automatic logic [PORT_IDX_W-1:0] rr_next(input logic [PORT_IDX_W-1:0] idx,
                                                    input int unsigned n);
    if ((32'(idx) + 32'd1) >= n) rr_next = '0;
    else                         rr_next = idx + PORT_IDX_W'(1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr wins.
module rr_pick #(
  parameter int unsigned N  = 2,
  parameter int unsigned IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  int unsigned   sum;
  logic [IW-1:0] j;
  logic          found;

  // Scan ports starting from ptr, wrapping once around the vector.
  always_comb begin
    gnt_c = '0;
    idx_c = '0;
    found = 1'b0;
    sum   = 0;
    j     = '0;
    for (int unsigned i = 0; i < N; i++) begin
      sum = 32'(ptr) + i;
      if (sum >= N) sum = sum - N;
      j = IW'(sum);
      if (!found && req[j]) begin
        found    = 1'b1;
        gnt_c[j] = 1'b1;
        idx_c    = j;
      end
    end
  end

  assign any_c = |req;

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between requesters.
// Optional address range check enabled by defining DMEM_ARB_RANGE_CHECK_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned NUM_PORTS = ARB_NUM_PORTS,
  parameter int unsigned ADDR_W    = ARB_ADDR_W,
  parameter int unsigned DATA_W    = ARB_DATA_W,
  parameter int unsigned DEPTH     = 256
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_PORTS-1:0]              req_i,
  input  logic [NUM_PORTS-1:0]              we_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr_i,
  input  logic [NUM_PORTS-1:0][DATA_W-1:0]  wdata_i,
  output logic [NUM_PORTS-1:0]              gnt_o,
  output logic [NUM_PORTS-1:0]              rvalid_o,
  output logic [DATA_W-1:0]                 rdata_o,
  output logic [NUM_PORTS-1:0]              err_o,
  output logic [ADDR_W-1:0]                 mem_addr_o,
  output logic                              mem_we_o,
  output logic                              mem_rd_o,
  output logic [DATA_W-1:0]                 mem_wd_o,
  input  logic [DATA_W-1:0]                 mem_rdata_i
);

  // The command struct is sized by the package, so the parameters must agree with it.
  if (NUM_PORTS != ARB_NUM_PORTS || ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W) begin : g_cfg_bad
    $error("dmem_arbiter: parameters must match dmem_arb_pkg widths");
  end
  if (DEPTH == 0) begin : g_depth_bad
    $error("dmem_arbiter: DEPTH must be non-zero");
  end

  state_t                 state_q, state_d;
  cmd_t                   cmd_q, cmd_d;
  logic [PORT_IDX_W-1:0]  rr_q, rr_d;
  logic [NUM_PORTS-1:0]   gnt_d, rvalid_d, err_d;
  logic [DATA_W-1:0]      rdata_d;
  logic [NUM_PORTS-1:0]   pick_gnt;
  logic [PORT_IDX_W-1:0]  pick_idx;
  logic                   pick_any;
  logic                   access_c;
  logic                   range_err_c;

  rr_pick #(
    .N  (NUM_PORTS),
    .IW (PORT_IDX_W)
  ) u_rr_pick (
    .req   (req_i),
    .ptr   (rr_q),
    .gnt_c (pick_gnt),
    .idx_c (pick_idx),
    .any_c (pick_any)
  );

  // Memory is only touched in ACCESS; reset kills the strobes in the same cycle.
  assign access_c = (state_q == ACCESS) && !rst;

`ifdef DMEM_ARB_RANGE_CHECK_EN
  assign range_err_c = (cmd_q.addr >= ADDR_W'(DEPTH));
`else
  assign range_err_c = 1'b0;
`endif

  // Memory-side drive from the latched command.
  always_comb begin
    mem_addr_o = '0;
    mem_wd_o   = '0;
    mem_we_o   = 1'b0;
    mem_rd_o   = 1'b0;
    if (access_c) begin
      mem_addr_o = cmd_q.addr;
      mem_wd_o   = cmd_q.wdata;
      mem_we_o   = cmd_q.we && !range_err_c;
      mem_rd_o   = !cmd_q.we && !range_err_c;
    end
  end

  // Next-state, command capture and response generation.
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    rr_d     = rr_q;
    gnt_d    = '0;
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = rdata_o;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d     = ACCESS;
          gnt_d       = pick_gnt;
          cmd_d.idx   = pick_idx;
          cmd_d.we    = we_i[pick_idx];
          cmd_d.addr  = addr_i[pick_idx];
          cmd_d.wdata = wdata_i[pick_idx];
        end
      end
      ACCESS: begin
        state_d = IDLE;
        rr_d    = rr_next(cmd_q.idx, NUM_PORTS);
        if (!cmd_q.we) begin
          rvalid_d = gnt_o;
          rdata_d  = range_err_c ? '0 : mem_rdata_i;
        end
        if (range_err_c) err_d = gnt_o;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, command and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      rr_q     <= '0;
      gnt_o    <= '0;
      rvalid_o <= '0;
      err_o    <= '0;
      rdata_o  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      rr_q     <= rr_d;
      gnt_o    <= gnt_d;
      rvalid_o <= rvalid_d;
      err_o    <= err_d;
      rdata_o  <= rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural single-port memory.
module tb_dmem_arbiter;

  localparam int unsigned NP = 2;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]         req, we;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0][DW-1:0] wdata;
  logic [NP-1:0]         gnt, rvalid, err;
  logic [DW-1:0]         rdata, mem_wd, mem_rdata;
  logic [AW-1:0]         mem_addr;
  logic                  mem_we, mem_rd;
  logic [DW-1:0]         mem [0:511];

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .we_i        (we),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .gnt_o       (gnt),
    .rvalid_o    (rvalid),
    .rdata_o     (rdata),
    .err_o       (err),
    .mem_addr_o  (mem_addr),
    .mem_we_o    (mem_we),
    .mem_rd_o    (mem_rd),
    .mem_wd_o    (mem_wd),
    .mem_rdata_i (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr[8:0]];
  always @(posedge clk) if (mem_we) mem[mem_addr[8:0]] <= mem_wd;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    req = '0; we = '0; addr = '0; wdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin fails++; $display("FAIL reset_rvalid: got %b expected 00", rvalid); end
    checks++; if (err !== 2'b00) begin fails++; $display("FAIL reset_err: got %b expected 00", err); end
    checks++; if (rdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    checks++; if ({mem_we, mem_rd} !== 2'b00) begin fails++; $display("FAIL reset_strobes: got %b expected 00", {mem_we, mem_rd}); end
    checks++; if (mem_addr !== 32'h0) begin fails++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
  endtask

  task automatic test_write_read();
    do_reset();
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'd5; wdata[0] = 32'hDEADBEEF;
    tick();
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL wr_gnt: got %b expected 01", gnt); end
    checks++; if ({mem_we, mem_rd} !== 2'b10) begin fails++; $display("FAIL wr_strobes: got %b expected 10", {mem_we, mem_rd}); end
    checks++; if (mem_addr !== 32'd5 || mem_wd !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_bus: got %h/%h expected 5/deadbeef", mem_addr, mem_wd); end
    clear_reqs();
    tick();
    checks++; if ({mem_we, mem_rd, gnt} !== 4'b0000) begin fails++; $display("FAIL wr_idle: got %b expected 0000", {mem_we, mem_rd, gnt}); end
    checks++; if (rvalid !== 2'b00) begin fails++; $display("FAIL wr_no_rvalid: got %b expected 00", rvalid); end
    checks++; if (mem[5] !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_commit: got %h expected deadbeef", mem[5]); end
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'd5;
    tick();
    checks++; if ({mem_we, mem_rd} !== 2'b01) begin fails++; $display("FAIL rd_strobes: got %b expected 01", {mem_we, mem_rd}); end
    checks++; if (rvalid !== 2'b00) begin fails++; $display("FAIL rd_early_rvalid: got %b expected 00", rvalid); end
    clear_reqs();
    tick();
    checks++; if (rvalid !== 2'b01) begin fails++; $display("FAIL rd_rvalid: got %b expected 01", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_data: got %h expected deadbeef", rdata); end
    tick();
    checks++; if (rvalid !== 2'b00) begin fails++; $display("FAIL rd_pulse: got %b expected 00", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_hold: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_gnt [7];
    logic [1:0] exp_rv  [7];
    logic [DW-1:0] exp_d;
    exp_gnt = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    exp_rv  = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};
    do_reset();
    req = 2'b11; we = 2'b00; addr[0] = 32'd20; addr[1] = 32'd21;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++; if (gnt !== exp_gnt[i]) begin fails++; $display("FAIL alt_gnt[%0d]: got %b expected %b", i, gnt, exp_gnt[i]); end
      checks++; if (rvalid !== exp_rv[i]) begin fails++; $display("FAIL alt_rvalid[%0d]: got %b expected %b", i, rvalid, exp_rv[i]); end
      if (exp_rv[i] != 2'b00) begin
        exp_d = (exp_rv[i] == 2'b01) ? 32'h11111111 : 32'h22222222;
        checks++; if (rdata !== exp_d) begin fails++; $display("FAIL alt_rdata[%0d]: got %h expected %h", i, rdata, exp_d); end
      end
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_late_request();
    do_reset();
    req[0] = 1'b1; addr[0] = 32'd20;
    tick();
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL late_gnt0: got %b expected 01", gnt); end
    req[0] = 1'b0; req[1] = 1'b1; addr[1] = 32'd21;
    tick();
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL late_idle_gnt: got %b expected 00", gnt); end
    checks++; if (rvalid !== 2'b01) begin fails++; $display("FAIL late_rvalid0: got %b expected 01", rvalid); end
    tick();
    checks++; if (gnt !== 2'b10) begin fails++; $display("FAIL late_gnt1: got %b expected 10", gnt); end
    clear_reqs();
    tick();
    checks++; if (rvalid !== 2'b10 || rdata !== 32'h22222222) begin fails++; $display("FAIL late_rvalid1: got %b/%h expected 10/22222222", rvalid, rdata); end
    tick();
    checks++; if (gnt !== 2'b00) begin fails++; $display("FAIL late_no_extra_gnt: got %b expected 00", gnt); end
  endtask

  task automatic test_reset_mid_access();
    do_reset();
    req[0] = 1'b1; addr[0] = 32'd5;
    tick();
    req[0] = 1'b0;
    tick();
    req[0] = 1'b1;
    tick();
    checks++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL rma_live_read: got %b expected 1", mem_rd); end
    rst = 1'b1;
    #1;
    checks++; if ({mem_we, mem_rd} !== 2'b00) begin fails++; $display("FAIL rma_strobes: got %b expected 00", {mem_we, mem_rd}); end
    clear_reqs();
    tick();
    rst = 1'b0;
    checks++; if ({rvalid, gnt} !== 4'b0000) begin fails++; $display("FAIL rma_after: got %b expected 0000", {rvalid, gnt}); end
    tick();
    checks++; if (rvalid !== 2'b00) begin fails++; $display("FAIL rma_no_rvalid: got %b expected 00", rvalid); end
    req = 2'b11; addr[0] = 32'd20; addr[1] = 32'd21;
    tick();
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL rma_rr_ptr: got %b expected 01", gnt); end
    clear_reqs();
    tick();
    checks++; if (rvalid !== 2'b01 || rdata !== 32'h11111111) begin fails++; $display("FAIL rma_resume: got %b/%h expected 01/11111111", rvalid, rdata); end
  endtask

  task automatic test_range();
    logic          exp_rd;
    logic [1:0]    exp_err;
    logic [DW-1:0] exp_d;
`ifdef DMEM_ARB_RANGE_CHECK_EN
    exp_rd = 1'b0; exp_err = 2'b01; exp_d = 32'h0;
`else
    exp_rd = 1'b1; exp_err = 2'b00; exp_d = 32'hCAFEF00D;
`endif
    do_reset();
    req[0] = 1'b1; addr[0] = 32'd255;
    tick();
    checks++; if (mem_rd !== 1'b1) begin fails++; $display("FAIL rng255_rd: got %b expected 1", mem_rd); end
    clear_reqs();
    tick();
    checks++; if ({err, rvalid} !== 4'b0001 || rdata !== 32'h0FF00FF0) begin fails++; $display("FAIL rng255_resp: got %b/%h expected 0001/0ff00ff0", {err, rvalid}, rdata); end
    req[0] = 1'b1; addr[0] = 32'd300;
    tick();
    checks++; if (gnt !== 2'b01) begin fails++; $display("FAIL rng300_gnt: got %b expected 01", gnt); end
    checks++; if (mem_rd !== exp_rd || mem_we !== 1'b0) begin fails++; $display("FAIL rng300_strobes: got %b%b expected 0%b", mem_we, mem_rd, exp_rd); end
    clear_reqs();
    tick();
    checks++; if (err !== exp_err) begin fails++; $display("FAIL rng300_err: got %b expected %b", err, exp_err); end
    checks++; if (rvalid !== 2'b01 || rdata !== exp_d) begin fails++; $display("FAIL rng300_resp: got %b/%h expected 01/%h", rvalid, rdata, exp_d); end
    tick();
    checks++; if (err !== 2'b00) begin fails++; $display("FAIL rng_err_pulse: got %b expected 00", err); end
  endtask

  task automatic test_write_then_read();
    do_reset();
    req = 2'b11; we = 2'b01;
    addr[0] = 32'd10; wdata[0] = 32'h12345678; addr[1] = 32'd10;
    tick();
    checks++; if (gnt !== 2'b01 || {mem_we, mem_rd} !== 2'b10) begin fails++; $display("FAIL wtr_write: got %b/%b expected 01/10", gnt, {mem_we, mem_rd}); end
    req[0] = 1'b0;
    tick();
    checks++; if ({mem_we, mem_rd} !== 2'b00) begin fails++; $display("FAIL wtr_gap: got %b expected 00", {mem_we, mem_rd}); end
    tick();
    checks++; if (gnt !== 2'b10 || {mem_we, mem_rd} !== 2'b01 || mem_addr !== 32'd10) begin fails++; $display("FAIL wtr_read: got %b/%b/%h expected 10/01/a", gnt, {mem_we, mem_rd}, mem_addr); end
    clear_reqs();
    tick();
    checks++; if (rvalid !== 2'b10 || rdata !== 32'h12345678) begin fails++; $display("FAIL wtr_data: got %b/%h expected 10/12345678", rvalid, rdata); end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = '0;
    mem[20]  = 32'h11111111;
    mem[21]  = 32'h22222222;
    mem[255] = 32'h0FF00FF0;
    mem[300] = 32'hCAFEF00D;
    rst = 1'b1;
    clear_reqs();
    test_reset();
    test_write_read();
    test_alternate();
    test_late_request();
    test_reset_mid_access();
    test_range();
    test_write_then_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
